// File: rtl/ex_mem_elastic_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_elastic_pipe_if
//  Purpose  : valid/ready beat bus between the execute and data-memory stages.
//             Carries one packed control word, one packed data word and a
//             halt marker per beat.
//  Signals  : valid - beat present (driven by master)
//             ready - receiver accepts (driven by slave)
//             ctrl  - CTRL_W control fields {mem_rd_src, mem_wr_src,
//                     mem_write, wb, mem_to_reg}
//             data  - DATA_W data fields {bus_b, alu_result, addr_wr}
//             halt  - beat is a halt
//  Modports : master drives valid/ctrl/data/halt, slave drives ready.
//  Revision : 1.0  initial release
// ============================================================================
interface ex_mem_elastic_pipe_if #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 64
) ();
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic              halt;

    modport master (output valid, output ctrl, output data, output halt, input  ready);
    modport slave  (input  valid, input  ctrl, input  data, input  halt, output ready);
endinterface
`default_nettype wire

// File: rtl/ex_mem_elastic_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_elastic_pipe
//  Purpose  : EX->MEM pipeline register chain of DEPTH two-entry skid stages
//             with valid/ready flow control. Sustains one beat per cycle under
//             backpressure; supports flush-to-bubble, global freeze, an
//             occupancy count and halt draining.
//  Ports    : i_clk       - clock, rising edge
//             i_reset     - synchronous active-high reset
//             i_enable    - global advance enable (0 = freeze)
//             i_flush     - synchronous flush of every in-flight beat
//             up          - upstream beat bus (slave side)
//             dn          - downstream beat bus (master side)
//             o_count     - beats currently held, 0..2*DEPTH
//             o_halt_seen - sticky, a halt beat has left the block
//  Revision : 1.0  initial release
// ============================================================================
module ex_mem_elastic_pipe #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(2*DEPTH+1)
) (
    input  wire logic                 i_clk,
    input  wire logic                 i_reset,
    input  wire logic                 i_enable,
    input  wire logic                 i_flush,
    ex_mem_elastic_pipe_if.slave      up,
    ex_mem_elastic_pipe_if.master     dn,
    output      logic [CNT_W-1:0]     o_count,
    output      logic                 o_halt_seen
);

    // Per-stage views of the main register and skid-full flag
    logic [DEPTH-1:0]  w_main_v;
    logic [DEPTH-1:0]  w_skid_v;
    logic [CTRL_W-1:0] w_main_ctrl [DEPTH];
    logic [DATA_W-1:0] w_main_data [DEPTH];
    logic [DEPTH-1:0]  w_main_halt;

    // Beat offered to each stage and the ready seen at each stage output
    logic [DEPTH-1:0]  w_up_v;
    logic [CTRL_W-1:0] w_up_ctrl [DEPTH];
    logic [DATA_W-1:0] w_up_data [DEPTH];
    logic [DEPTH-1:0]  w_up_halt;
    logic [DEPTH-1:0]  w_dn_rdy;

    logic              w_accept;
    logic              w_deliver;
    logic              r_drain;
    logic              r_halt_seen;
    logic [CNT_W-1:0]  r_count;

    // Stage-0 ready is the registered skid flag, so no path exists from
    // dn.ready to up.ready.
    assign up.ready  = !w_skid_v[0] && i_enable && !i_reset && !i_flush
                       && !r_drain && !r_halt_seen;
    assign w_accept  = up.valid && up.ready;

    assign dn.valid  = w_main_v[DEPTH-1] && i_enable;
    assign dn.ctrl   = w_main_ctrl[DEPTH-1];
    assign dn.data   = w_main_data[DEPTH-1];
    assign dn.halt   = w_main_halt[DEPTH-1];
    assign w_deliver = dn.valid && dn.ready;

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        logic              r_main_v;
        logic [CTRL_W-1:0] r_main_ctrl;
        logic [DATA_W-1:0] r_main_data;
        logic              r_main_halt;
        logic              r_skid_v;
        logic [CTRL_W-1:0] r_skid_ctrl;
        logic [DATA_W-1:0] r_skid_data;
        logic              r_skid_halt;
        logic              w_in_fire;
        logic              w_out_fire;

        if (s == 0) begin : g_head
            assign w_up_v[s]    = w_accept;
            assign w_up_ctrl[s] = up.ctrl;
            assign w_up_data[s] = up.data;
            assign w_up_halt[s] = up.halt;
        end else begin : g_body
            assign w_up_v[s]    = w_main_v[s-1];
            assign w_up_ctrl[s] = w_main_ctrl[s-1];
            assign w_up_data[s] = w_main_data[s-1];
            assign w_up_halt[s] = w_main_halt[s-1];
        end

        if (s == DEPTH-1) begin : g_tail
            assign w_dn_rdy[s] = dn.ready;
        end else begin : g_inner
            assign w_dn_rdy[s] = !w_skid_v[s+1];
        end

        assign w_in_fire  = w_up_v[s] && !r_skid_v;
        assign w_out_fire = r_main_v && w_dn_rdy[s];

        always_ff @(posedge i_clk) begin
            if (i_reset || i_flush) begin
                r_main_v    <= 1'b0;
                r_main_ctrl <= '0;
                r_main_data <= '0;
                r_main_halt <= 1'b0;
                r_skid_v    <= 1'b0;
                r_skid_ctrl <= '0;
                r_skid_data <= '0;
                r_skid_halt <= 1'b0;
            end else if (i_enable) begin
                if (r_skid_v) begin
                    // Skid full means the stage refused input; drain skid into main first.
                    if (w_out_fire) begin
                        r_main_v    <= 1'b1;
                        r_main_ctrl <= r_skid_ctrl;
                        r_main_data <= r_skid_data;
                        r_main_halt <= r_skid_halt;
                        r_skid_v    <= 1'b0;
                        r_skid_ctrl <= '0;
                        r_skid_data <= '0;
                        r_skid_halt <= 1'b0;
                    end
                end else if (!r_main_v || w_out_fire) begin
                    // Empty slots are zeroed so a bubble presents mem_write=0, wb=0.
                    r_main_v    <= w_in_fire;
                    r_main_ctrl <= w_in_fire ? w_up_ctrl[s] : '0;
                    r_main_data <= w_in_fire ? w_up_data[s] : '0;
                    r_main_halt <= w_in_fire && w_up_halt[s];
                end else if (w_in_fire) begin
                    r_skid_v    <= 1'b1;
                    r_skid_ctrl <= w_up_ctrl[s];
                    r_skid_data <= w_up_data[s];
                    r_skid_halt <= w_up_halt[s];
                end
            end
        end

        assign w_main_v[s]    = r_main_v;
        assign w_skid_v[s]    = r_skid_v;
        assign w_main_ctrl[s] = r_main_ctrl;
        assign w_main_data[s] = r_main_data;
        assign w_main_halt[s] = r_main_halt;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count     <= '0;
            r_drain     <= 1'b0;
            r_halt_seen <= 1'b0;
        end else if (i_flush) begin
            // The halt history survives a flush; only in-flight state is dropped.
            r_count <= '0;
            r_drain <= 1'b0;
        end else if (i_enable) begin
            if (w_accept && !w_deliver) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_accept && w_deliver) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_accept && up.halt) begin
                r_drain <= 1'b1;
            end else if (w_deliver && dn.halt) begin
                r_drain <= 1'b0;
            end
            if (w_deliver && dn.halt) begin
                r_halt_seen <= 1'b1;
            end
        end
    end

    assign o_count     = r_count;
    assign o_halt_seen = r_halt_seen;

endmodule
`default_nettype wire
